// File: rtl/mem_loader.sv
// Byte-stream RAM loader with read-back verify.
// Little-endian byte pairs from a valid/ready stream are assembled into 16-bit
// words and written to consecutive RAM addresses 0..len. A running checksum is
// kept of every written word. The region is then read back through a
// registered-read port, and the read-back sum is compared with the checksum.
module mem_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic [7:0]  inByte,
   input  logic        inValid,
   output logic        inReady,
   output logic [7:0]  addrWr,
   output logic [15:0] dataWr,
   output logic        wrEn,
   output logic [7:0]  addrRd,
   input  logic [15:0] dataRd,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] checksum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_WRITE,
      S_VERIFY,
      S_FLUSH,
      S_DONE
   } state_e;

   state_e      state_q;
   logic [7:0]  len_q;        // last word address of the current load
   logic [7:0]  wr_addr_q;    // address of the word being assembled
   logic [7:0]  lo_q;         // low byte of the word being assembled
   logic [7:0]  addr_wr_q;
   logic [15:0] data_wr_q;
   logic        wr_en_q;
   logic [7:0]  addr_rd_q;    // also serves as the verify read counter
   logic        rd_valid_q;   // dataRd carries the answer to last cycle's read
   logic [15:0] vsum_q;       // sum of read-back words
   logic [15:0] checksum_q;
   logic        in_ready_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;

   logic        xfer;         // a byte moves this cycle
   logic [15:0] vsum_d;       // read-back sum including this cycle's dataRd

   assign xfer   = inValid & in_ready_q;
   assign vsum_d = vsum_q + dataRd;

   // Loader FSM: every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; reset is synchronous and wins over all else.
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= 8'd0;
         wr_addr_q  <= 8'd0;
         lo_q       <= 8'd0;
         addr_wr_q  <= 8'd0;
         data_wr_q  <= 16'd0;
         wr_en_q    <= 1'b0;
         addr_rd_q  <= 8'd0;
         rd_valid_q <= 1'b0;
         vsum_q     <= 16'd0;
         checksum_q <= 16'd0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse; the HI->WRITE step re-arms it.
         wr_en_q    <= 1'b0;
         // A read issued in VERIFY returns data on the following cycle.
         rd_valid_q <= (state_q == S_VERIFY);
         if (rd_valid_q) begin
            vsum_q <= vsum_d;
         end

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len_q      <= len;
                  wr_addr_q  <= 8'd0;
                  checksum_q <= 16'd0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
                  state_q    <= S_LO;
               end
            end

            S_LO: begin
               if (xfer) begin
                  lo_q    <= inByte;
                  state_q <= S_HI;
               end
            end

            S_HI: begin
               if (xfer) begin
                  addr_wr_q  <= wr_addr_q;
                  data_wr_q  <= {inByte, lo_q};
                  wr_en_q    <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= S_WRITE;
               end
            end

            S_WRITE: begin
               checksum_q <= checksum_q + data_wr_q;
               // Compare before incrementing so len=255 finishes without wrap.
               if (wr_addr_q == len_q) begin
                  addr_rd_q <= 8'd0;
                  vsum_q    <= 16'd0;
                  state_q   <= S_VERIFY;
               end else begin
                  wr_addr_q  <= wr_addr_q + 8'd1;
                  in_ready_q <= 1'b1;
                  state_q    <= S_LO;
               end
            end

            S_VERIFY: begin
               if (addr_rd_q == len_q) begin
                  state_q <= S_FLUSH;
               end else begin
                  addr_rd_q <= addr_rd_q + 8'd1;
               end
            end

            S_FLUSH: begin
               // The last read's data arrives now; compare the completed sum.
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               error_q <= (vsum_d != checksum_q);
               state_q <= S_DONE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign inReady  = in_ready_q;
   assign addrWr   = addr_wr_q;
   assign dataWr   = data_wr_q;
   assign wrEn     = wr_en_q;
   assign addrRd   = addr_rd_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a registered-read RAM model with optional
// read corruption, a per-cycle observation log, and a word-level reference
// (expected write list, modular sums, verify latency) derived from the rules.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [7:0]  inByte;
   logic        inValid;
   logic        inReady;
   logic [7:0]  addrWr;
   logic [15:0] dataWr;
   logic        wrEn;
   logic [7:0]  addrRd;
   logic [15:0] dataRd;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] checksum;

   always #5 clk = ~clk;

   mem_loader dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .inByte(inByte), .inValid(inValid), .inReady(inReady),
      .addrWr(addrWr), .dataWr(dataWr), .wrEn(wrEn),
      .addrRd(addrRd), .dataRd(dataRd),
      .busy(busy), .done(done), .error(error), .checksum(checksum)
   );

   // RAM model: synchronous write, registered read, optional bit-8 corruption.
   logic [15:0] ram [256];
   bit          corrupt_en;
   logic [7:0]  corrupt_addr;
   always @(posedge clk) begin
      if (wrEn) ram[addrWr] <= dataWr;
      dataRd <= ram[addrRd] ^ ((corrupt_en && addrRd == corrupt_addr) ? 16'h0100 : 16'h0000);
   end

   // One log entry per cycle, sampled mid-cycle.
   typedef struct packed {
      logic        wr_en;
      logic [7:0]  addr_wr;
      logic [15:0] data_wr;
      logic        in_ready;
      logic [7:0]  addr_rd;
      logic        done;
   } obs_t;
   obs_t log_q[$];
   bit   log_en = 1'b0;
   always @(negedge clk) if (log_en) log_q.push_back({wrEn, addrWr, dataWr, inReady, addrRd, done});

   int          tests_run = 0;
   int          fails = 0;
   logic [15:0] wq[$];        // words of the current load, address order
   logic [7:0]  wr_a[$];
   logic [15:0] wr_d[$];
   logic        wr_r[$];

   task automatic do_start(input logic [7:0] l);
      @(negedge clk);
      log_q.delete();
      log_en = 1'b1;
      start = 1'b1;
      len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer bytes first..first+count-1 (low byte of each word first).
   // mode 0: always valid, 1: valid toggles 1/0, 2: random valid.
   task automatic drive_bytes(input int first, input int count, input int mode);
      int idx = first;
      int cyc = 0;
      bit x;
      while (idx < first + count && cyc < 8 * count + 40) begin
         @(negedge clk);
         inValid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         inByte  = (idx % 2 == 0) ? wq[idx / 2][7:0] : wq[idx / 2][15:8];
         x = inValid && inReady;
         @(posedge clk);
         if (x) idx++;
         cyc++;
      end
      @(negedge clk);
      inValid = 1'b0;
      if (idx < first + count) begin
         tests_run++; fails++;
         $display("FAIL drive_timeout: transferred %0d bytes, required %0d", idx - first, count);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 1000) begin @(negedge clk); n++; end
      tests_run++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
      @(negedge clk);
   endtask

   // Extract writes from the log; done_idx is the first done=1 after the last write.
   task automatic analyze(output int nw, output int last_w, output int done_idx);
      nw = 0; last_w = -1; done_idx = -1;
      wr_a.delete(); wr_d.delete(); wr_r.delete();
      foreach (log_q[i]) begin
         if (log_q[i].wr_en) begin
            wr_a.push_back(log_q[i].addr_wr);
            wr_d.push_back(log_q[i].data_wr);
            wr_r.push_back(log_q[i].in_ready);
            nw++;
            last_w = i;
         end
         if (log_q[i].done && done_idx < 0 && last_w >= 0 && i > last_w) done_idx = i;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = 8'd0; inByte = 8'd0; inValid = 1'b0; corrupt_en = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({inReady, wrEn, addrWr, dataWr, addrRd, busy, done, error, checksum} !== 53'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h required 0",
                  {inReady, wrEn, addrWr, dataWr, addrRd, busy, done, error, checksum});
      end
      rst = 1'b0;
      inValid = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({inReady, wrEn, busy} !== 3'b000) begin
         fails++; $display("FAIL idle_quiet: inReady/wrEn/busy=%b required 000", {inReady, wrEn, busy});
      end
      inValid = 1'b0;
   endtask

   task automatic test_single();
      int nw, lw, di;
      wq = '{16'h1234};
      do_start(8'd0);
      drive_bytes(0, 2, 0);
      wait_done();
      analyze(nw, lw, di);
      tests_run++; if (nw !== 1) begin fails++; $display("FAIL single_nwrites: got %0d required 1", nw); end
      if (nw >= 1) begin
         tests_run++; if (wr_a[0] !== 8'h00) begin fails++; $display("FAIL single_addr: got %h required 00", wr_a[0]); end
         tests_run++; if (wr_d[0] !== 16'h1234) begin fails++; $display("FAIL single_data: got %h required 1234", wr_d[0]); end
         tests_run++; if (log_q[lw + 1].addr_rd !== 8'h00) begin fails++; $display("FAIL single_addrrd: got %h required 00", log_q[lw + 1].addr_rd); end
      end
      tests_run++; if (checksum !== 16'h1234) begin fails++; $display("FAIL single_checksum: got %h required 1234", checksum); end
      tests_run++; if ({done, error} !== 2'b10) begin fails++; $display("FAIL single_status: done/error=%b required 10", {done, error}); end
      tests_run++; if (di - (lw + 1) !== 2) begin fails++; $display("FAIL single_latency: got %0d required 2", di - (lw + 1)); end
   endtask

   task automatic test_toggle();
      int nw, lw, di;
      wq = '{16'h0001, 16'h0002, 16'h0003};
      do_start(8'd2);
      drive_bytes(0, 6, 1);
      wait_done();
      analyze(nw, lw, di);
      tests_run++; if (nw !== 3) begin fails++; $display("FAIL toggle_nwrites: got %0d required 3", nw); end
      for (int i = 0; i < nw && i < 3; i++) begin
         tests_run++;
         if (wr_a[i] !== 8'(i) || wr_d[i] !== wq[i] || wr_r[i] !== 1'b0) begin
            fails++;
            $display("FAIL toggle_write%0d: addr=%h data=%h inReady=%b required addr=%h data=%h inReady=0",
                     i, wr_a[i], wr_d[i], wr_r[i], 8'(i), wq[i]);
         end
      end
      tests_run++; if (checksum !== 16'h0006) begin fails++; $display("FAIL toggle_checksum: got %h required 0006", checksum); end
      tests_run++; if (error !== 1'b0) begin fails++; $display("FAIL toggle_error: got %b required 0", error); end
   endtask

   task automatic test_wrap();
      int nw, lw, di;
      wq = '{16'hFFFF, 16'h0002};
      do_start(8'd1);
      drive_bytes(0, 4, 0);
      wait_done();
      analyze(nw, lw, di);
      tests_run++; if (nw !== 2) begin fails++; $display("FAIL wrap_nwrites: got %0d required 2", nw); end
      tests_run++; if (checksum !== 16'h0001) begin fails++; $display("FAIL wrap_checksum: got %h required 0001", checksum); end
      tests_run++; if ({done, error} !== 2'b10) begin fails++; $display("FAIL wrap_status: done/error=%b required 10", {done, error}); end
   endtask

   task automatic test_corrupt();
      logic [15:0] sum = 16'd0;
      wq.delete();
      for (int i = 0; i < 4; i++) begin wq.push_back(16'($urandom)); sum += wq[i]; end
      corrupt_en = 1'b1; corrupt_addr = 8'd2;
      do_start(8'd3);
      drive_bytes(0, 8, 0);
      wait_done();
      corrupt_en = 1'b0;
      tests_run++; if (checksum !== sum) begin fails++; $display("FAIL corrupt_checksum: got %h required %h", checksum, sum); end
      tests_run++; if ({done, error} !== 2'b11) begin fails++; $display("FAIL corrupt_status: done/error=%b required 11", {done, error}); end
   endtask

   task automatic test_reset_midload();
      int nw, lw, di;
      wq = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789};
      do_start(8'd3);
      drive_bytes(0, 3, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({inReady, wrEn, addrWr, dataWr, addrRd, busy, done, error, checksum} !== 53'd0) begin
         fails++;
         $display("FAIL midload_reset: got %h required 0",
                  {inReady, wrEn, addrWr, dataWr, addrRd, busy, done, error, checksum});
      end
      log_q.delete();
      inValid = 1'b1; inByte = 8'h55;
      repeat (10) @(negedge clk);
      inValid = 1'b0;
      analyze(nw, lw, di);
      tests_run++; if (nw !== 0) begin fails++; $display("FAIL midload_nowrite: got %0d writes required 0", nw); end
      wq = '{16'h5A3C};
      do_start(8'd0);
      drive_bytes(0, 2, 0);
      wait_done();
      analyze(nw, lw, di);
      tests_run++;
      if (nw !== 1 || wr_a[0] !== 8'h00 || wr_d[0] !== 16'h5A3C) begin
         fails++; $display("FAIL midload_restart: nwrites=%0d first addr/data=%h/%h required 1 00/5a3c", nw, wr_a[0], wr_d[0]);
      end
   endtask

   task automatic test_ignored_start();
      int nw, lw, di;
      logic [15:0] sum = 16'd0;
      wq.delete();
      for (int i = 0; i < 4; i++) begin wq.push_back(16'($urandom)); sum += wq[i]; end
      do_start(8'd3);
      drive_bytes(0, 1, 0);             // now waiting for the high byte
      start = 1'b1; len = 8'd9;
      @(negedge clk);
      start = 1'b0;
      drive_bytes(1, 7, 0);             // returns during the final WRITE
      @(negedge clk);                   // first VERIFY cycle
      start = 1'b1; len = 8'd200;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      analyze(nw, lw, di);
      tests_run++; if (nw !== 4) begin fails++; $display("FAIL ignore_nwrites: got %0d required 4", nw); end
      tests_run++; if (checksum !== sum) begin fails++; $display("FAIL ignore_checksum: got %h required %h", checksum, sum); end
      tests_run++; if (di - (lw + 1) !== 5) begin fails++; $display("FAIL ignore_latency: got %0d required 5", di - (lw + 1)); end
      tests_run++; if ({done, error} !== 2'b10) begin fails++; $display("FAIL ignore_status: done/error=%b required 10", {done, error}); end
   endtask

   // Back-to-back random loads, each started straight from DONE; the last one
   // covers the full 256-word address range.
   task automatic test_back_to_back();
      int nw, lw, di, bad, l;
      logic [15:0] sum, rsum;
      bit exp_err;
      for (int r = 0; r < 7; r++) begin
         l = (r == 6) ? 255 : $urandom_range(0, 12);
         wq.delete(); sum = 16'd0; rsum = 16'd0;
         corrupt_en = 1'($urandom_range(0, 1));
         corrupt_addr = 8'($urandom_range(0, 15));
         for (int i = 0; i <= l; i++) begin
            wq.push_back(16'($urandom));
            sum += wq[i];
            rsum += wq[i] ^ ((corrupt_en && i == int'(corrupt_addr)) ? 16'h0100 : 16'h0000);
         end
         exp_err = (rsum != sum);
         do_start(8'(l));
         tests_run++;
         if ({busy, done, checksum} !== 18'b10_0000_0000_0000_0000) begin
            fails++; $display("FAIL b2b_restart%0d: busy/done/checksum=%b/%b/%h required 1/0/0000", r, busy, done, checksum);
         end
         drive_bytes(0, 2 * (l + 1), $urandom_range(0, 2));
         wait_done();
         analyze(nw, lw, di);
         bad = 0;
         for (int i = 0; i < nw && i <= l; i++) if (wr_a[i] !== 8'(i) || wr_d[i] !== wq[i]) bad++;
         for (int k = 0; k <= l && lw + 1 + k < log_q.size(); k++) if (log_q[lw + 1 + k].addr_rd !== 8'(k)) bad++;
         tests_run++;
         if (nw !== l + 1 || bad !== 0) begin
            fails++; $display("FAIL b2b_writes%0d: nwrites=%0d bad=%0d required %0d and 0", r, nw, bad, l + 1);
         end
         tests_run++; if (di - (lw + 1) !== l + 2) begin fails++; $display("FAIL b2b_latency%0d: got %0d required %0d", r, di - (lw + 1), l + 2); end
         tests_run++; if (checksum !== sum) begin fails++; $display("FAIL b2b_checksum%0d: got %h required %h", r, checksum, sum); end
         tests_run++; if (error !== exp_err) begin fails++; $display("FAIL b2b_error%0d: got %b required %b", r, error, exp_err); end
      end
      corrupt_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_toggle();
      test_wrap();
      test_corrupt();
      test_reset_midload();
      test_ignored_start();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
